// File: rtl/pipe_run_monitor.sv
// rtl/pipe_run_monitor.sv - run monitor for the 5-stage core: cycle count, PC halt/timeout detection, register-change trace
module pipe_run_monitor #(
    parameter int PC_W        = 7,
    parameter int DATA_W      = 32,
    parameter int NREG        = 16,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 29,
    parameter int STALL_LIMIT = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               start,
    input  logic [PC_W-1:0]                                    pc_in,
    input  logic [NREG*DATA_W-1:0]                             regs_in,
    output logic                                               running,
    output logic                                               done,
    output logic [1:0]                                         reason,
    output logic [CNT_W-1:0]                                   cycles,
    output logic [$clog2(DEPTH):0]                             trace_cnt,
    output logic                                               wrapped,
    output logic                                               multi_chg,
    input  logic [$clog2(DEPTH)-1:0]                           rd_idx,
    output logic [CNT_W+PC_W+$clog2(NREG)+DATA_W-1:0]          rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(NREG);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam int EW = CNT_W + PC_W + IW + DATA_W;
    localparam logic [1:0] RSN_NONE = 2'b00;
    localparam logic [1:0] RSN_HALT = 2'b01;
    localparam logic [1:0] RSN_TMO  = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   start_run;
    logic [CNT_W-1:0]       cycles_q;
    logic [CNT_W-1:0]       cyc_next;
    logic [AW:0]            tcnt_q;
    logic [AW-1:0]          wr_ptr;
    logic [SW-1:0]          stall_cnt;
    logic [SW-1:0]          stall_next;
    logic [PC_W-1:0]        prev_pc;
    logic [NREG*DATA_W-1:0] prev_regs;
    logic [NREG-1:0]        chg;
    logic                   any_chg;
    logic                   multi_now;
    logic [IW-1:0]          low_idx;
    logic [DATA_W-1:0]      low_val;
    logic                   halt_hit;
    logic                   tmo_hit;
    logic                   full;
    logic [AW-1:0]          rd_addr;
    logic [EW-1:0]          mem [DEPTH];

    always_comb begin
        chg = '0;
        for (int i = 0; i < NREG; i++) begin
            chg[i] = regs_in[i*DATA_W +: DATA_W] != prev_regs[i*DATA_W +: DATA_W];
        end
    end

    // Scan downward so the last hit is the lowest changed index.
    always_comb begin
        low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (chg[i]) low_idx = IW'(i);
        end
    end

    assign low_val    = regs_in[low_idx*DATA_W +: DATA_W];
    assign any_chg    = |chg;
    assign multi_now  = (chg & (chg - NREG'(1))) != '0;
    assign cyc_next   = cycles_q + CNT_W'(1);
    assign stall_next = (pc_in == prev_pc) ? stall_cnt + SW'(1) : '0;
    assign halt_hit   = stall_next >= SW'(STALL_LIMIT);
    assign tmo_hit    = cyc_next == CNT_W'(MAX_CYCLES);
    assign full       = tcnt_q == (AW+1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (halt_hit || tmo_hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycles_q  <= '0;
            tcnt_q    <= '0;
            wr_ptr    <= '0;
            wrapped   <= 1'b0;
            multi_chg <= 1'b0;
            stall_cnt <= '0;
            reason    <= RSN_NONE;
            prev_pc   <= '0;
            prev_regs <= '0;
        end else if (start_run) begin
            cycles_q  <= '0;
            tcnt_q    <= '0;
            wr_ptr    <= '0;
            wrapped   <= 1'b0;
            multi_chg <= 1'b0;
            stall_cnt <= '0;
            reason    <= RSN_NONE;
            prev_pc   <= pc_in;
            prev_regs <= regs_in;
        end else if (state_q == RUN) begin
            cycles_q  <= cyc_next;
            stall_cnt <= stall_next;
            prev_pc   <= pc_in;
            prev_regs <= regs_in;
            if (any_chg) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (full) wrapped <= 1'b1;
                else      tcnt_q  <= tcnt_q + (AW+1)'(1);
            end
            if (multi_now) multi_chg <= 1'b1;
            if (halt_hit)     reason <= RSN_HALT;
            else if (tmo_hit) reason <= RSN_TMO;
        end
    end

    // Trace storage is deliberately unreset; reads are only meaningful below trace_cnt.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == RUN && any_chg) begin
            mem[wr_ptr] <= {cyc_next, pc_in, low_idx, low_val};
        end
    end

    assign rd_addr   = wr_ptr - tcnt_q[AW-1:0] + rd_idx;
    assign rd_data   = mem[rd_addr];
    assign running   = state_q == RUN;
    assign done      = state_q == DONE;
    assign cycles    = cycles_q;
    assign trace_cnt = tcnt_q;
endmodule

// File: tb/tb_pipe_run_monitor.sv
// tb/tb_pipe_run_monitor.sv - self-checking bench for pipe_run_monitor against a queue-based run model
module tb_pipe_run_monitor;
    localparam int NREG  = 16;
    localparam int DEPTH = 16;
    localparam int MAXC  = 29;
    localparam int STALL = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [6:0]   pc_in;
    logic [511:0] regs_in;
    logic         running;
    logic         done;
    logic [1:0]   reason;
    logic [15:0]  cycles;
    logic [4:0]   trace_cnt;
    logic         wrapped;
    logic         multi_chg;
    logic [3:0]   rd_idx;
    logic [58:0]  rd_data;

    int total = 0;
    int bad   = 0;

    logic [6:0]  cur_pc;
    logic [31:0] cur_regs [NREG];
    logic [6:0]  m_pc;
    logic [31:0] m_regs [NREG];
    int          m_cyc, m_stall, m_reason;
    bit          m_done, m_wrapped, m_multi;
    logic [58:0] q [$];
    logic [31:0] fifth_val;

    pipe_run_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in), .regs_in(regs_in),
        .running(running), .done(done), .reason(reason), .cycles(cycles),
        .trace_cnt(trace_cnt), .wrapped(wrapped), .multi_chg(multi_chg),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        pc_in = cur_pc;
        for (int i = 0; i < NREG; i++) regs_in[i*32 +: 32] = cur_regs[i];
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_running"}, 64'(running), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_reason"}, 64'(reason), 0);
        chk({tag, "_cycles"}, 64'(cycles), 0);
        chk({tag, "_tcnt"}, 64'(trace_cnt), 0);
        chk({tag, "_wrapped"}, 64'(wrapped), 0);
        chk({tag, "_multi"}, 64'(multi_chg), 0);
    endtask

    // Run-level model: a run is a sequence of (pc, regs) samples; the log is a bounded FIFO of changes.
    task automatic model_step();
        int n;
        int lo;
        n  = 0;
        lo = -1;
        m_cyc++;
        for (int i = 0; i < NREG; i++) begin
            if (cur_regs[i] != m_regs[i]) begin
                n++;
                if (lo < 0) lo = i;
            end
        end
        if (n > 0) begin
            q.push_back({m_cyc[15:0], cur_pc, lo[3:0], cur_regs[lo]});
            if (q.size() > DEPTH) begin
                q = q[1:$];
                m_wrapped = 1'b1;
            end
        end
        if (n >= 2) m_multi = 1'b1;
        m_stall = (cur_pc == m_pc) ? m_stall + 1 : 0;
        m_pc    = cur_pc;
        m_regs  = cur_regs;
        if (m_stall >= STALL) begin
            m_done   = 1'b1;
            m_reason = 1;
        end else if (m_cyc == MAXC) begin
            m_done   = 1'b1;
            m_reason = 2;
        end
    endtask

    task automatic gen(input int mode, input int k);
        int r;
        case (mode)
            0: cur_pc = 7'(k);
            1: cur_pc = (k < 6) ? 7'(k) : 7'h14;
            2: begin
                cur_pc = 7'(k);
                if (k == 3) cur_regs[1] = 32'h5;
            end
            3: begin
                cur_pc = 7'(k);
                if (k == 2) begin
                    cur_regs[0] = cur_regs[0] ^ 32'h0000_0101;
                    cur_regs[8] = cur_regs[8] ^ 32'h0001_0000;
                end
            end
            4: begin
                cur_pc = 7'(k + 40);
                if (k <= 20) begin
                    r = $urandom_range(0, NREG - 1);
                    cur_regs[r] = cur_regs[r] ^ ($urandom | 32'h1);
                    if (k == 5) fifth_val = cur_regs[r];
                end
            end
            default: begin
                cur_pc = 7'($urandom_range(0, 1));
                for (int i = 0; i < NREG; i++)
                    if ($urandom_range(0, 7) == 0) cur_regs[i] = cur_regs[i] ^ ($urandom | 32'h1);
            end
        endcase
    endtask

    task automatic begin_run();
        cur_pc = 7'h0;
        for (int i = 0; i < NREG; i++) cur_regs[i] = $urandom;
        apply();
        start = 1'b1;
        tick();
        start     = 1'b0;
        m_cyc     = 0;
        m_stall   = 0;
        m_reason  = 0;
        m_done    = 1'b0;
        m_wrapped = 1'b0;
        m_multi   = 1'b0;
        m_pc      = cur_pc;
        m_regs    = cur_regs;
        q.delete();
        chk("run_entry_running", 64'(running), 1);
        chk("run_entry_cycles", 64'(cycles), 0);
        chk("run_entry_tcnt", 64'(trace_cnt), 0);
    endtask

    task automatic run(input int mode);
        int k;
        logic [15:0] frozen;
        begin_run();
        k = 0;
        while (!m_done && k < 100) begin
            k++;
            gen(mode, k);
            apply();
            start = (mode >= 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            start = 1'b0;
            model_step();
            chk("cycles", 64'(cycles), 64'(m_cyc));
            if (!m_done) chk("running", 64'(running), 1);
        end
        chk("done", 64'(done), 1);
        chk("reason", 64'(reason), 64'(m_reason));
        chk("tcnt", 64'(trace_cnt), 64'(q.size()));
        chk("wrapped", 64'(wrapped), 64'(m_wrapped));
        chk("multi", 64'(multi_chg), 64'(m_multi));
        for (int i = 0; i < q.size(); i++) begin
            rd_idx = 4'(i);
            #1;
            chk("rd_data", 64'(rd_data), 64'(q[i]));
        end
        frozen = cycles;
        for (int i = 0; i < 2; i++) begin
            cur_pc = cur_pc + 7'd3;
            cur_regs[i] = ~cur_regs[i];
            apply();
            tick();
        end
        chk("frozen_done", 64'(done), 1);
        chk("frozen_cycles", 64'(cycles), 64'(frozen));
        chk("frozen_tcnt", 64'(trace_cnt), 64'(q.size()));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        rd_idx = '0;
        for (int i = 0; i < NREG; i++) cur_regs[i] = '0;
        cur_pc = '0;
        apply();
        tick();
        tick();
        chk_reset_state("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_running", 64'(running), 0);

        run(0);
        chk("tmo_cycles", 64'(cycles), 29);
        chk("tmo_reason", 64'(reason), 2);
        chk("tmo_tcnt", 64'(trace_cnt), 0);

        run(1);
        chk("halt_cycles", 64'(cycles), 10);
        chk("halt_reason", 64'(reason), 1);

        run(2);
        rd_idx = 4'd0;
        #1;
        chk("t1_entry", 64'(rd_data), {5'd0, 16'd3, 7'd3, 4'd1, 32'h5});
        chk("t1_tcnt", 64'(trace_cnt), 1);

        run(3);
        rd_idx = 4'd0;
        #1;
        chk("multi_flag", 64'(multi_chg), 1);
        chk("multi_tcnt", 64'(trace_cnt), 1);
        chk("multi_idx", 64'(rd_data[35:32]), 0);
        chk("multi_cyc", 64'(rd_data[58:43]), 2);

        run(4);
        rd_idx = 4'd0;
        #1;
        chk("wrap_tcnt", 64'(trace_cnt), 16);
        chk("wrap_flag", 64'(wrapped), 1);
        chk("wrap_oldest_val", 64'(rd_data[31:0]), 64'(fifth_val));
        chk("wrap_oldest_cyc", 64'(rd_data[58:43]), 5);

        for (int n = 0; n < 6; n++) run(5);

        begin_run();
        for (int k = 1; k <= 5; k++) begin
            gen(2, k);
            apply();
            tick();
        end
        cur_regs[7] = ~cur_regs[7];
        apply();
        rst_n = 1'b0;
        tick();
        chk_reset_state("midrun_reset");
        rst_n = 1'b1;
        run(0);
        chk("after_reset_reason", 64'(reason), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
